spi_flash_read_seq: RTL and testbench
=====================================

# spi_flash_read_seq

Bus-master sequencer that drives the SPI master's memory-mapped register port to perform SPI-flash READ (0x03) transfers of 1..256 32-bit words. It configures the controller, pushes the command and address word, and issues one 4-byte RX command per word. It pops each received word from the MISO FIFO and streams it out on a valid/ready port. It sits between a boot/DMA client and the SPI master, replacing CPU software polling.

## Interface
- `BASE_ADDR`, default 32'h2001_0000: SPI master register base. CTRL +0x0, STATUS +0x4, MISO +0x8, MOSI +0xC, CMD +0x10.
- `CLKDIV`, default 16'd4: written to CTRL[31:16].
- `CPOL`, default 0: written to CTRL[3].
- `CPHA`, default 0: written to CTRL[2].
- `TIMEOUT`, default 4096: maximum cycles spent retrying one register access.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `start_i` in 1: start request. Sampled only in IDLE.
- `flash_addr_i` in 24: flash byte address. Latched on start.
- `word_count_i` in 9: number of words, 1..256. Latched on start. 0 is treated as 256.
- `busy_o` out 1: transfer in progress.
- `done_o` out 1: one-cycle pulse at the end of every transfer.
- `error_o` out 1: sticky; cleared on the next accepted start.
- `rd_data_o` out 32: received word. The first flash byte is in bits [31:24].
- `rd_valid_o` out 1: `rd_data_o` is valid.
- `rd_ready_i` in 1: consumer accepts the word.
- `spi_enable_o` out 1: register-access strobe.
- `spi_addr_o` out 32: register address.
- `spi_din_o` out 32: register write data.
- `spi_dout_i` in 32: register read data.
- `spi_ready_i` in 1: access acknowledge.

## Operation
- States: IDLE, CFG, TXW, TXC, RXC, BAR, POP, OUT, FIN, ERR.
- **IDLE**: on `start_i`, latch the address and count, set `words_left` to the count, clear `error_o`, then go to CFG.
- **CFG**: write CTRL = {CLKDIV, 12'h0, CPOL, CPHA, 1'b0, 1'b1}. Go to TXW.
- **TXW**: write MOSI = {a[7:0], a[15:8], a[23:16], 8'h03}. The SPI master shifts the LSB byte first. Go to TXC.
- **TXC**: write CMD = {18'h0, 2'b10, 2'b00, 1'b1, 9'd4}. This is TX, CS held. Go to RXC.
- **RXC**: write CMD = {18'h0, 2'b01, 2'b00, hold, 9'd4}, with hold = (words_left != 1). Go to BAR.
- **BAR**: write CMD = 32'h0000_0200, an empty-loop command of length 0 with CS held. This is the barrier: its acknowledge proves the previous RX command has finished. Go to POP.
- **POP**: read MISO and capture `spi_dout_i` into `rd_data_o` on acknowledge. Go to OUT.
- **OUT**: assert `rd_valid_o`. On `rd_ready_i`, decrement `words_left`. If the result is 0, go to FIN; otherwise go to RXC.
- **FIN**: pulse `done_o`, then go to IDLE.
- **Access rule** (applies to every register write or read):
  - `spi_enable_o` is a one-cycle pulse with the address and data valid in that same cycle.
  - The acknowledge is expected exactly one cycle after the pulse.
  - If no acknowledge arrives, wait one idle cycle and re-pulse. The controller does not acknowledge CMD writes while it is busy.
  - A per-access counter resets at each new access. Reaching TIMEOUT goes to ERR.
- **ERR**: write CTRL with bit1 (rst) = 1 and enable = 0. Ignore its acknowledge. Set `error_o` and pulse `done_o`, then go to IDLE.
- A `start_i` while busy is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `spi_enable_o`, `busy_o`, `done_o`, `error_o`, `rd_valid_o`: 0.
  - `spi_addr_o`, `spi_din_o`, `rd_data_o`: 0.
- An uncontended access takes 2 cycles: pulse, then acknowledge.
- `busy_o` rises the cycle after `start_i` and falls in the FIN or ERR cycle that pulses `done_o`.
- `rd_data_o` stays stable while `rd_valid_o` is high and `rd_ready_i` is low. No new SPI traffic is issued during backpressure.
- Maximum one word in flight, so the MISO FIFO never exceeds one entry.
- `words_left` is a 9-bit count. Loading 0 means 256. Decrement does not wrap below 1 before FIN.
- `rst_i` mid-transfer returns the block to IDLE immediately with all outputs at their reset values. The SPI master is not touched.
- If `spi_ready_i` is high outside an expected acknowledge cycle, it is ignored.

## Configuration
- `SPI_FLASH_RD_TIMEOUT_EN`:
  - Defined: the TIMEOUT watchdog and the ERR path are compiled in.
  - Undefined: accesses retry indefinitely, ERR is unreachable, and `error_o` is tied to 0.

## Test plan
- Start with addr 0x123456 and count 1, using a model flash that returns DE AD BE EF:
  - MOSI write 0x5634_1203.
  - `rd_data_o` = 0xDEADBEEF.
  - `done_o` pulses once and CS deasserts after the RX command.
- Count 0 (meaning 256) with an incrementing-byte model:
  - 256 words out.
  - Word n = {4n, 4n+1, 4n+2, 4n+3} mod 256.
  - No MISO FIFO overflow.
- Hold `rd_ready_i` low for 50 cycles on word 2 of 3:
  - `rd_data_o` stays stable.
  - No `spi_enable_o` pulses occur during the stall.
- Controller stalls its CMD acknowledge for 30 cycles:
  - Re-pulses occur every 2 cycles.
  - The transfer completes correctly with no duplicate MOSI or CMD writes.
- With `SPI_FLASH_RD_TIMEOUT_EN` and TIMEOUT = 64, the acknowledge is never returned:
  - After 64 cycles, the CTRL reset write is issued.
  - `error_o` = 1 and `done_o` pulses.
  - The next start clears `error_o`.
- Assert `rst_i` in the POP state:
  - Next cycle, all outputs are 0 and the state is IDLE.
  - A new start proceeds normally.

Source files
------------

// File: rtl/spi_flash_read_seq.sv
// -----------------------------------------------------------------------------
// spi_flash_read_seq
//   Bus-master sequencer that runs SPI-flash READ (0x03) transfers of 1..256
//   32-bit words through the SPI master's register port. It configures the
//   controller, pushes the command/address word, then for every word issues a
//   4-byte RX command, a zero-length barrier command, and a MISO pop. Each
//   popped word is streamed out on a valid/ready port.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 start request (sampled only when idle)
//   flash_addr_i[23:0]      flash byte address, latched on start
//   word_count_i[8:0]       word count, latched on start (0 means 256)
//   busy_o, done_o, error_o transfer status (done_o is a 1-cycle pulse)
//   rd_data_o, rd_valid_o,
//   rd_ready_i              received-word stream, first flash byte in [31:24]
//   spi_enable_o, spi_addr_o,
//   spi_din_o, spi_dout_i,
//   spi_ready_i             SPI master register port
//
// Build option
//   SPI_FLASH_RD_TIMEOUT_EN  when defined, each register access is abandoned
//                            after TIMEOUT cycles without acknowledge; the
//                            controller is reset and error_o is raised.
// -----------------------------------------------------------------------------
module spi_flash_read_seq #(
   parameter logic [31:0] BASE_ADDR = 32'h2001_0000,
   parameter logic [15:0] CLKDIV    = 16'd4,
   parameter logic        CPOL      = 1'b0,
   parameter logic        CPHA      = 1'b0,
   parameter int          TIMEOUT   = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [23:0] flash_addr_i,
   input  logic [8:0]  word_count_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [31:0] rd_data_o,
   output logic        rd_valid_o,
   input  logic        rd_ready_i,
   output logic        spi_enable_o,
   output logic [31:0] spi_addr_o,
   output logic [31:0] spi_din_o,
   input  logic [31:0] spi_dout_i,
   input  logic        spi_ready_i
);

   localparam logic [3:0] S_IDLE = 4'd0, S_CFG = 4'd1, S_TXW = 4'd2, S_TXC = 4'd3,
                          S_RXC  = 4'd4, S_BAR = 4'd5, S_POP = 4'd6, S_OUT = 4'd7,
                          S_FIN  = 4'd8, S_ERR = 4'd9;

   localparam logic [31:0] A_CTRL   = BASE_ADDR;
   localparam logic [31:0] A_MISO   = BASE_ADDR + 32'h8;
   localparam logic [31:0] A_MOSI   = BASE_ADDR + 32'hC;
   localparam logic [31:0] A_CMD    = BASE_ADDR + 32'h10;
   localparam logic [31:0] CTRL_RUN = {CLKDIV, 12'h0, CPOL, CPHA, 1'b0, 1'b1};
   localparam logic [31:0] CTRL_RST = {CLKDIV, 12'h0, CPOL, CPHA, 1'b1, 1'b0};
   localparam logic [31:0] CMD_TX   = {18'h0, 2'b10, 2'b00, 1'b1, 9'd4};
   // Zero-length loop with CS held: its acknowledge means the RX before it is done.
   localparam logic [31:0] CMD_BAR  = 32'h0000_0200;

   logic [3:0]  r_state;
   logic        r_en;
   logic [31:0] r_addr;
   logic [31:0] r_din;
   logic [31:0] r_data;
   logic [23:0] r_faddr;
   logic [8:0]  r_left;

   function automatic logic [3:0] next_st(input logic [3:0] st);
      case (st)
         S_CFG:   return S_TXW;
         S_TXW:   return S_TXC;
         S_TXC:   return S_RXC;
         S_RXC:   return S_BAR;
         S_BAR:   return S_POP;
         default: return S_OUT;
      endcase
   endfunction

   function automatic logic [31:0] acc_addr(input logic [3:0] st);
      case (st)
         S_CFG:   return A_CTRL;
         S_TXW:   return A_MOSI;
         S_POP:   return A_MISO;
         default: return A_CMD;
      endcase
   endfunction

   // The master shifts MOSI LSB byte first, so the opcode sits in [7:0].
   function automatic logic [31:0] acc_data(input logic [3:0] st, input logic [23:0] fa,
                                            input logic [8:0] left);
      case (st)
         S_CFG:   return CTRL_RUN;
         S_TXW:   return {fa[7:0], fa[15:8], fa[23:16], 8'h03};
         S_TXC:   return CMD_TX;
         S_RXC:   return {18'h0, 2'b01, 2'b00, (left != 9'd1), 9'd4};
         S_BAR:   return CMD_BAR;
         default: return 32'h0;
      endcase
   endfunction

   // Register access states; the cycle after each pulse is the acknowledge slot.
   logic w_acc;
   logic w_ack_slot;
   assign w_acc      = (r_state >= S_CFG) && (r_state <= S_POP);
   assign w_ack_slot = w_acc && !r_en;

`ifdef SPI_FLASH_RD_TIMEOUT_EN
   logic [31:0] r_tmo;
   logic        r_err;
   logic        w_tmo;
   // Counts cycles since the current access first pulsed; cleared on acknowledge.
   always_ff @(posedge clk_i) begin
      if (rst_i || !w_acc || (w_ack_slot && spi_ready_i))
         r_tmo <= 32'd0;
      else
         r_tmo <= r_tmo + 32'd1;
   end
   assign w_tmo   = w_ack_slot && !spi_ready_i && (r_tmo >= 32'(TIMEOUT - 1));
   assign error_o = r_err;
`else
   logic [31:0] w_unused_tmo;
   assign w_unused_tmo = 32'(TIMEOUT);
   assign error_o      = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_en    <= 1'b0;
         r_addr  <= 32'h0;
         r_din   <= 32'h0;
         r_data  <= 32'h0;
         r_faddr <= 24'h0;
         r_left  <= 9'd0;
`ifdef SPI_FLASH_RD_TIMEOUT_EN
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (start_i) begin
               r_faddr <= flash_addr_i;
               r_left  <= (word_count_i == 9'd0) ? 9'd256 : word_count_i;
`ifdef SPI_FLASH_RD_TIMEOUT_EN
               r_err   <= 1'b0;
`endif
               r_state <= S_CFG;
               r_en    <= 1'b1;
               r_addr  <= A_CTRL;
               r_din   <= CTRL_RUN;
            end
            S_CFG, S_TXW, S_TXC, S_RXC, S_BAR, S_POP: begin
               if (r_en) begin
                  r_en <= 1'b0;
               end else if (spi_ready_i) begin
                  if (r_state == S_POP) begin
                     r_data  <= spi_dout_i;
                     r_state <= S_OUT;
                  end else begin
                     r_state <= next_st(r_state);
                     r_en    <= 1'b1;
                     r_addr  <= acc_addr(next_st(r_state));
                     r_din   <= acc_data(next_st(r_state), r_faddr, r_left);
                  end
`ifdef SPI_FLASH_RD_TIMEOUT_EN
               end else if (w_tmo) begin
                  r_state <= S_ERR;
                  r_en    <= 1'b1;
                  r_addr  <= A_CTRL;
                  r_din   <= CTRL_RST;
                  r_err   <= 1'b1;
`endif
               end else begin
                  // No acknowledge: the slot just passed was the idle cycle, re-pulse.
                  r_en <= 1'b1;
               end
            end
            S_OUT: if (rd_ready_i) begin
               r_left <= r_left - 9'd1;
               if (r_left == 9'd1) begin
                  r_state <= S_FIN;
               end else begin
                  r_state <= S_RXC;
                  r_en    <= 1'b1;
                  r_addr  <= A_CMD;
                  r_din   <= acc_data(S_RXC, r_faddr, r_left - 9'd1);
               end
            end
            S_FIN:   r_state <= S_IDLE;
            // Controller reset write is fire-and-forget; its acknowledge is ignored.
            S_ERR: begin
               r_en    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o       = (r_state != S_IDLE) && (r_state != S_FIN) && (r_state != S_ERR);
   assign done_o       = (r_state == S_FIN) || (r_state == S_ERR);
   assign rd_valid_o   = (r_state == S_OUT);
   assign rd_data_o    = r_data;
   assign spi_enable_o = r_en;
   assign spi_addr_o   = r_addr;
   assign spi_din_o    = r_din;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_read_seq
//   Directed bench for spi_flash_read_seq. A behavioural SPI master answers
//   register accesses one cycle after each pulse, can refuse CMD writes for a
//   window of cycles, and returns flash words from a pattern model.
// -----------------------------------------------------------------------------
module tb_spi_flash_read_seq;

   localparam logic [31:0] BASE   = 32'h2001_0000;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_MISO = BASE + 32'h8;
   localparam logic [31:0] A_MOSI = BASE + 32'hC;
   localparam logic [31:0] A_CMD  = BASE + 32'h10;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, rd_ready_i;
   logic [23:0] flash_addr_i;
   logic [8:0]  word_count_i;
   logic        busy_o, done_o, error_o, rd_valid_o, spi_enable_o;
   logic [31:0] rd_data_o, spi_addr_o, spi_din_o;
   logic [31:0] spi_dout_i = 32'h0;
   logic        spi_ready_i = 1'b0;

   spi_flash_read_seq #(.TIMEOUT(64)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .flash_addr_i(flash_addr_i), .word_count_i(word_count_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
      .spi_enable_o(spi_enable_o), .spi_addr_o(spi_addr_o), .spi_din_o(spi_din_o),
      .spi_dout_i(spi_dout_i), .spi_ready_i(spi_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Flash content model: mode 0 = DE AD BE EF, mode 1 = incrementing bytes.
   function automatic logic [31:0] pat(input int mode, input int n);
      logic [7:0] b;
      if (mode == 0) return 32'hDEAD_BEEF;
      b = 8'(4 * n);
      return {b, b + 8'd1, b + 8'd2, b + 8'd3};
   endfunction

   // ---------------- SPI master model ----------------
   int          pat_mode = 0, nack_until = 0;
   bit          no_ack = 0;
   int          cyc = 0, en_cnt = 0, mosi_cnt = 0, cmd_cnt = 0, hold_cnt = 0, nohold_cnt = 0;
   int          nack_cnt = 0, bad_int = 0, last_pulse = 0, depth = 0, max_depth = 0, pop_idx = 0;
   bit          last_nacked = 0;
   logic [31:0] mosi_last = 32'h0, ctrl_last = 32'h0;
   logic        acc_ok;
   assign acc_ok = !no_ack && !((spi_addr_o == A_CMD) && (cyc < nack_until));

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      spi_ready_i <= 1'b0;
      if (spi_enable_o) begin
         en_cnt <= en_cnt + 1;
         if (last_nacked && (cyc - last_pulse != 2)) bad_int <= bad_int + 1;
         last_pulse  <= cyc;
         last_nacked <= !acc_ok;
         if (!acc_ok) begin
            nack_cnt <= nack_cnt + 1;
         end else begin
            spi_ready_i <= 1'b1;
            case (spi_addr_o)
               A_CTRL: ctrl_last <= spi_din_o;
               A_MOSI: begin mosi_last <= spi_din_o; mosi_cnt <= mosi_cnt + 1; end
               A_CMD: begin
                  cmd_cnt <= cmd_cnt + 1;
                  if (spi_din_o == 32'h0000_2204) begin
                     depth <= 0; pop_idx <= 0;
                  end else if (spi_din_o == 32'h0000_1204 || spi_din_o == 32'h0000_1004) begin
                     depth <= depth + 1;
                     if (depth + 1 > max_depth) max_depth <= depth + 1;
                     if (spi_din_o[9]) hold_cnt <= hold_cnt + 1;
                     else              nohold_cnt <= nohold_cnt + 1;
                  end
               end
               A_MISO: begin
                  spi_dout_i <= pat(pat_mode, pop_idx);
                  pop_idx    <= pop_idx + 1;
                  if (depth > 0) depth <= depth - 1;
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- transfer driver / consumer ----------------
   task automatic run_xfer(input logic [23:0] a, input logic [8:0] cnt, input int mode,
                           input int stall_word, output int nw, output logic [31:0] lastw);
      int          n = 0, en0, unstable;
      bit          stalled = 0, fin = 0;
      logic [31:0] held;
      pat_mode = mode;
      flash_addr_i = a; word_count_i = cnt; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("busy_rise", 32'(busy_o), 1);
      lastw = 32'h0;
      for (int k = 0; k < 4000 && !fin; k++) begin
         rd_ready_i = !(n == stall_word && !stalled);
         if (done_o) begin
            fin = 1;
            chk("busy_fall", 32'(busy_o), 0);
         end else if (rd_valid_o) begin
            if (!rd_ready_i) begin
               held = rd_data_o; en0 = en_cnt; unstable = 0;
               repeat (50) begin
                  @(negedge clk_i);
                  if (!rd_valid_o || rd_data_o !== held) unstable++;
               end
               chk("stall_stable", unstable, 0);
               chk("stall_no_spi", en_cnt - en0, 0);
               stalled = 1; rd_ready_i = 1'b1;
            end
            chk($sformatf("word%0d", n), rd_data_o, pat(mode, n));
            lastw = rd_data_o;
            n++;
         end
         if (!fin) @(negedge clk_i);
      end
      rd_ready_i = 1'b1;
      chk("done_seen", 32'(fin), 1);
      @(negedge clk_i);
      chk("done_pulse", 32'(done_o), 0);
      nw = n;
   endtask

   typedef struct {
      logic [23:0] addr;
      logic [8:0]  cnt;
      int          mode;
      int          stall_word;
      int          nack;
      logic [31:0] exp_mosi;
      int          exp_words;
      logic [31:0] exp_last;
   } vec_t;

   vec_t        vecs[4];
   int          nw, m0, c0, h0, nh0, k0, t0;
   logic [31:0] lw;
   bit          found;

   initial begin
      vecs[0] = '{24'h123456, 9'd1, 0, -1, 0,  32'h5634_1203, 1,   32'hDEAD_BEEF};
      vecs[1] = '{24'h000000, 9'd0, 1, -1, 0,  32'h0000_0003, 256, 32'hFCFD_FEFF};
      vecs[2] = '{24'hABCDEF, 9'd3, 1, 1,  0,  32'hEFCD_AB03, 3,   32'h0809_0A0B};
      vecs[3] = '{24'h00FF01, 9'd2, 1, -1, 30, 32'h01FF_0003, 2,   32'h0405_0607};

      rst_i = 1'b1; start_i = 1'b0; rd_ready_i = 1'b1;
      flash_addr_i = 24'h0; word_count_i = 9'd0;
      repeat (3) @(negedge clk_i);
      chk("rst_status", {28'h0, busy_o, done_o, error_o, rd_valid_o}, 0);
      chk("rst_enable", 32'(spi_enable_o), 0);
      chk("rst_addr", spi_addr_o, 0);
      chk("rst_din", spi_din_o, 0);
      chk("rst_data", rd_data_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      foreach (vecs[i]) begin
         m0 = mosi_cnt; c0 = cmd_cnt; h0 = hold_cnt; nh0 = nohold_cnt; k0 = nack_cnt;
         nack_until = (vecs[i].nack > 0) ? cyc + vecs[i].nack : 0;
         run_xfer(vecs[i].addr, vecs[i].cnt, vecs[i].mode, vecs[i].stall_word, nw, lw);
         chk($sformatf("v%0d_mosi", i), mosi_last, vecs[i].exp_mosi);
         chk($sformatf("v%0d_mosi_cnt", i), mosi_cnt - m0, 1);
         chk($sformatf("v%0d_cmd_cnt", i), cmd_cnt - c0, 1 + 2 * vecs[i].exp_words);
         chk($sformatf("v%0d_rx_hold", i), hold_cnt - h0, vecs[i].exp_words - 1);
         chk($sformatf("v%0d_rx_cs_release", i), nohold_cnt - nh0, 1);
         chk($sformatf("v%0d_ctrl", i), ctrl_last, 32'h0004_0001);
         chk($sformatf("v%0d_nwords", i), nw, vecs[i].exp_words);
         chk($sformatf("v%0d_last_word", i), lw, vecs[i].exp_last);
         chk($sformatf("v%0d_error", i), 32'(error_o), 0);
         chk($sformatf("v%0d_nacked", i), 32'(nack_cnt - k0 > 0), 32'(vecs[i].nack > 0));
      end
      chk("repulse_interval", bad_int, 0);
      chk("fifo_max_depth", max_depth, 1);

      // Reset while the MISO pop is on the bus.
      pat_mode = 1; flash_addr_i = 24'h000040; word_count_i = 9'd2; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         if (spi_enable_o && spi_addr_o == A_MISO) found = 1;
         else @(negedge clk_i);
      end
      chk("pop_reached", 32'(found), 1);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_status", {28'h0, busy_o, done_o, error_o, rd_valid_o}, 0);
      chk("midrst_enable", 32'(spi_enable_o), 0);
      chk("midrst_addr", spi_addr_o, 0);
      chk("midrst_din", spi_din_o, 0);
      chk("midrst_data", rd_data_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
      run_xfer(24'h000010, 9'd1, 1, -1, nw, lw);
      chk("postrst_mosi", mosi_last, 32'h1000_0003);
      chk("postrst_word", lw, 32'h0001_0203);

`ifdef SPI_FLASH_RD_TIMEOUT_EN
      // Controller never acknowledges: watchdog fires after 64 cycles.
      no_ack = 1; flash_addr_i = 24'h000100; word_count_i = 9'd1; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      found = 0; t0 = -1;
      for (int k = 0; k < 200 && !found; k++) begin
         if (spi_enable_o && t0 < 0) t0 = cyc;
         if (spi_enable_o && spi_addr_o == A_CTRL && spi_din_o == 32'h0004_0002) begin
            found = 1;
            chk("tmo_cycles", 32'(cyc - t0), 64);
            chk("tmo_error", 32'(error_o), 1);
            chk("tmo_done", 32'(done_o), 1);
            chk("tmo_busy", 32'(busy_o), 0);
         end else @(negedge clk_i);
      end
      chk("tmo_reset_write", 32'(found), 1);
      @(negedge clk_i);
      chk("tmo_error_sticky", 32'(error_o), 1);
      chk("tmo_done_pulse", 32'(done_o), 0);
      no_ack = 0;
      run_xfer(24'h000200, 9'd1, 0, -1, nw, lw);
      chk("tmo_error_cleared", 32'(error_o), 0);
      chk("tmo_recover_word", lw, 32'hDEAD_BEEF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
